// File: rtl/tpu_package.sv
// Shared TPU parameters and types used by the unified-buffer read path.
package tpu_package;

  // Systolic array lane count and lane width (ACT_WIDTH+1 bits per lane).
  localparam int unsigned MUL_SIZE  = 4;
  localparam int unsigned ACT_WIDTH = 7;

  // Unified-buffer addressing and job length limits.
  localparam int unsigned UB_ADDR_W = 12;
  localparam int unsigned ROW_CNT_W = 13;

  // Depth of the row FIFO between the unified buffer and the consumer.
  localparam int unsigned UB_FIFO_DEPTH = 2;

  typedef logic [MUL_SIZE-1:0][ACT_WIDTH:0] ub_row_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } ub_seq_state_t;

  // Row address = base + offset, wrapping inside the 12-bit address space.
  function automatic logic [UB_ADDR_W-1:0] ub_row_addr(
    input logic [UB_ADDR_W-1:0] base,
    input logic [ROW_CNT_W-1:0] offset
  );
    return base + offset[UB_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ub_row_fifo.sv
// Small synchronous FIFO holding rows returned by the unified buffer.
// The head entry is presented combinationally; a pop and a push in the
// same cycle leave the occupancy unchanged.
module ub_row_fifo
  import tpu_package::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = UB_FIFO_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Push/pop qualification; a push into a full FIFO is only allowed alongside a pop.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    do_pop  = rd_en_i && !empty_o;
    do_push = wr_en_i && (!full || do_pop);
  end

  // Storage array.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/ub_read_sequencer.sv
// Streams a block of consecutive unified-buffer rows to a ready/valid
// consumer. Reads are credit-limited so that every returned row has a
// FIFO slot waiting for it.
module ub_read_sequencer
  import tpu_package::*;
(
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [UB_ADDR_W-1:0]               base_addr_i,
  input  logic [ROW_CNT_W-1:0]               num_rows_i,
  output logic                               ub_read_o,
  output logic [UB_ADDR_W-1:0]               ub_addr_rd_o,
  input  logic [MUL_SIZE-1:0][ACT_WIDTH:0]   ub_data_i,
  output logic                               row_valid_o,
  input  logic                               row_ready_i,
  output logic [MUL_SIZE-1:0][ACT_WIDTH:0]   row_data_o,
  output logic                               row_last_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int unsigned ROW_W  = MUL_SIZE * (ACT_WIDTH + 1);
  localparam int unsigned FCNT_W = $clog2(UB_FIFO_DEPTH + 1);

  ub_seq_state_t          state_q, state_d;
  logic [UB_ADDR_W-1:0]   base_q;
  logic [ROW_CNT_W-1:0]   num_q;
  logic [ROW_CNT_W-1:0]   issued_q;
  logic                   inflight_q;
  logic                   inflight_last_q;

  logic                   accept;
  logic                   issue;
  logic                   last_issue;
  logic                   credit;
  logic [2:0]             occupancy;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic [FCNT_W-1:0]      fifo_count;
  logic [ROW_W:0]         fifo_head;
  logic                   head_last;

  // Credit counts the FIFO occupancy after this cycle's pop; a slot freed by a
  // same-cycle pop is reusable immediately, which keeps one row per cycle
  // flowing while never over-committing the two FIFO entries.
  always_comb begin
    accept     = (state_q == SEQ_IDLE) && start_i;
    fifo_pop   = !fifo_empty && row_ready_i;
    head_last  = fifo_head[ROW_W];
    occupancy  = 3'(fifo_count) - 3'(fifo_pop) + 3'(inflight_q);
    credit     = (occupancy < 3'(UB_FIFO_DEPTH));
    issue      = (state_q == SEQ_RUN) && credit;
    last_issue = issue && (issued_q == (num_q - 1'b1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start_i) state_d = (num_rows_i == '0) ? SEQ_DONE : SEQ_RUN;
      end
      SEQ_RUN: begin
        if (last_issue) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (fifo_pop && head_last) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= SEQ_IDLE;
    else        state_q <= state_d;
  end

  // Job parameters, issue counter and the single in-flight read tracker.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base_q          <= '0;
      num_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (accept) begin
        base_q   <= base_addr_i;
        num_q    <= num_rows_i;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  // Returned rows are captured one cycle after their read, tagged with last.
  ub_row_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (UB_FIFO_DEPTH)
  ) u_row_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (inflight_q),
    .wr_data_i ({inflight_last_q, ub_data_i}),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Output drive; the read address is held at zero when no read is issued.
  always_comb begin
    ub_read_o    = issue;
    ub_addr_rd_o = issue ? ub_row_addr(base_q, issued_q) : '0;
    row_valid_o  = !fifo_empty;
    row_data_o   = fifo_head[ROW_W-1:0];
    row_last_o   = !fifo_empty && head_last;
    busy_o       = (state_q != SEQ_IDLE);
    done_o       = (state_q == SEQ_DONE);
  end

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Directed bench for ub_read_sequencer with a one-cycle-latency memory model.
module tb_ub_read_sequencer;
  import tpu_package::*;

  logic                             clk_i = 1'b0;
  logic                             rst_i = 1'b0;
  logic                             start_i = 1'b0;
  logic [11:0]                      base_addr_i = '0;
  logic [12:0]                      num_rows_i = '0;
  logic                             ub_read_o;
  logic [11:0]                      ub_addr_rd_o;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0] ub_data_i = '0;
  logic                             row_valid_o;
  logic                             row_ready_i = 1'b0;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0] row_data_o;
  logic                             row_last_o;
  logic                             busy_o;
  logic                             done_o;

  ub_read_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .num_rows_i   (num_rows_i),
    .ub_read_o    (ub_read_o),
    .ub_addr_rd_o (ub_addr_rd_o),
    .ub_data_i    (ub_data_i),
    .row_valid_o  (row_valid_o),
    .row_ready_i  (row_ready_i),
    .row_data_o   (row_data_o),
    .row_last_o   (row_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [11:0] rd_q[$];
  int          rd_cyc_q[$];
  logic [32:0] row_q[$];

  // Row content the memory returns for a given address.
  function automatic logic [31:0] exp_row(input logic [11:0] a);
    return {a[11:4], a[7:0] ^ 8'h5A, a[3:0], a[11:8], a[7:0]};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory: data valid one cycle after the read, held otherwise.
  always @(posedge clk_i) if (ub_read_o) ub_data_i <= exp_row(ub_addr_rd_o);

  // Log reads, transfers and done pulses mid-cycle.
  always @(negedge clk_i) begin
    if (ub_read_o) begin
      rd_q.push_back(ub_addr_rd_o);
      rd_cyc_q.push_back(cyc);
    end
    if (row_valid_o && row_ready_i) row_q.push_back({row_last_o, row_data_o});
    if (done_o) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic clear_log();
    rd_q.delete();
    rd_cyc_q.delete();
    row_q.delete();
    done_cnt = 0;
  endtask

  // Start is accepted on the second posedge; returns 1 time unit after it.
  task automatic start_job(input logic [11:0] b, input logic [12:0] n);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = b; num_rows_i = n;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (done_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (ub_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_ub_read: got %b want 0", ub_read_o); end
    n_checks++; if (ub_addr_rd_o !== 12'h000) begin n_fail++; $display("FAIL reset_ub_addr: got %h want 000", ub_addr_rd_o); end
    n_checks++; if (row_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid: got %b want 0", row_valid_o); end
    n_checks++; if (row_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_row_data: got %h want 0", row_data_o); end
    n_checks++; if (row_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_row_last: got %b want 0", row_last_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_streaming();
    bit ok;
    logic [32:0] e;
    clear_log();
    row_ready_i = 1'b1;
    start_job(12'h010, 13'd4);
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL stream_busy: got %b want 1", busy_o); end
    n_checks++; if (ub_read_o !== 1'b1 || ub_addr_rd_o !== 12'h010) begin n_fail++; $display("FAIL stream_first_read: got rd=%b addr=%h want rd=1 addr=010", ub_read_o, ub_addr_rd_o); end
    n_checks++; if (row_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c1: got %b want 0", row_valid_o); end
    @(negedge clk_i);
    n_checks++; if (row_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c2: got %b want 0", row_valid_o); end
    @(negedge clk_i);
    n_checks++; if (row_valid_o !== 1'b1 || row_data_o !== exp_row(12'h010) || row_last_o !== 1'b0) begin n_fail++; $display("FAIL stream_first_row: got v=%b d=%h l=%b want v=1 d=%h l=0", row_valid_o, row_data_o, row_last_o, exp_row(12'h010)); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_done_timeout: got no done want done"); end
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got busy=%b done=%b want 0 0", busy_o, done_o); end
    n_checks++; if (rd_q.size() != 4) begin n_fail++; $display("FAIL stream_read_count: got %0d want 4", rd_q.size()); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      n_checks++; if (rd_q[i] !== 12'(12'h010 + i) || rd_cyc_q[i] != rd_cyc_q[0] + i) begin n_fail++; $display("FAIL stream_read_%0d: got addr=%h cyc+%0d want addr=%h cyc+%0d", i, rd_q[i], rd_cyc_q[i] - rd_cyc_q[0], 12'(12'h010 + i), i); end
    end
    n_checks++; if (row_q.size() != 4) begin n_fail++; $display("FAIL stream_row_count: got %0d want 4", row_q.size()); end
    for (int i = 0; i < 4 && i < row_q.size(); i++) begin
      e = {(i == 3), exp_row(12'(12'h010 + i))};
      n_checks++; if (row_q[i] !== e) begin n_fail++; $display("FAIL stream_row_%0d: got %h want %h", i, row_q[i], e); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stream_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [11:0] ea;
    logic [32:0] e;
    clear_log();
    row_ready_i = 1'b1;
    start_job(12'hFFE, 13'd3);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout: got no done want done"); end
    @(negedge clk_i);
    n_checks++; if (rd_q.size() != 3) begin n_fail++; $display("FAIL wrap_read_count: got %0d want 3", rd_q.size()); end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      ea = 12'hFFE + 12'(i);
      n_checks++; if (rd_q[i] !== ea) begin n_fail++; $display("FAIL wrap_addr_%0d: got %h want %h", i, rd_q[i], ea); end
    end
    for (int i = 0; i < 3 && i < row_q.size(); i++) begin
      ea = 12'hFFE + 12'(i);
      e  = {(i == 2), exp_row(ea)};
      n_checks++; if (row_q[i] !== e) begin n_fail++; $display("FAIL wrap_row_%0d: got %h want %h", i, row_q[i], e); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [32:0] e;
    clear_log();
    row_ready_i = 1'b0;
    start_job(12'h100, 13'd5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i >= 2) begin
        n_checks++; if (row_valid_o !== 1'b1 || row_data_o !== exp_row(12'h100) || row_last_o !== 1'b0) begin n_fail++; $display("FAIL bp_stall_c%0d: got v=%b d=%h want v=1 d=%h", i + 1, row_valid_o, row_data_o, exp_row(12'h100)); end
      end
    end
    n_checks++; if (rd_q.size() > 2) begin n_fail++; $display("FAIL bp_stall_reads: got %0d want <=2", rd_q.size()); end
    @(posedge clk_i); #1;
    row_ready_i = 1'b1;
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: got no done want done"); end
    @(negedge clk_i);
    n_checks++; if (rd_q.size() != 5 || row_q.size() != 5) begin n_fail++; $display("FAIL bp_counts: got reads=%0d rows=%0d want 5 5", rd_q.size(), row_q.size()); end
    for (int i = 0; i < 5 && i < row_q.size(); i++) begin
      e = {(i == 4), exp_row(12'(12'h100 + i))};
      n_checks++; if (row_q[i] !== e) begin n_fail++; $display("FAIL bp_row_%0d: got %h want %h", i, row_q[i], e); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_rows();
    clear_log();
    row_ready_i = 1'b1;
    start_job(12'h123, 13'd0);
    @(negedge clk_i);
    n_checks++; if (done_o !== 1'b1 || busy_o !== 1'b1 || ub_read_o !== 1'b0) begin n_fail++; $display("FAIL zero_c1: got done=%b busy=%b rd=%b want 1 1 0", done_o, busy_o, ub_read_o); end
    @(negedge clk_i);
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_c2: got done=%b busy=%b want 0 0", done_o, busy_o); end
    n_checks++; if (rd_q.size() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_summary: got reads=%0d done=%0d want 0 1", rd_q.size(), done_cnt); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [32:0] e;
    clear_log();
    row_ready_i = 1'b1;
    start_job(12'h200, 13'd4);
    start_job(12'h300, 13'd2);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_done_timeout: got no done want done"); end
    @(negedge clk_i); @(negedge clk_i);
    n_checks++; if (rd_q.size() != 4 || row_q.size() != 4 || done_cnt != 1) begin n_fail++; $display("FAIL busy_counts: got reads=%0d rows=%0d done=%0d want 4 4 1", rd_q.size(), row_q.size(), done_cnt); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      n_checks++; if (rd_q[i] !== 12'(12'h200 + i)) begin n_fail++; $display("FAIL busy_addr_%0d: got %h want %h", i, rd_q[i], 12'(12'h200 + i)); end
    end
    for (int i = 0; i < 4 && i < row_q.size(); i++) begin
      e = {(i == 3), exp_row(12'(12'h200 + i))};
      n_checks++; if (row_q[i] !== e) begin n_fail++; $display("FAIL busy_row_%0d: got %h want %h", i, row_q[i], e); end
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    logic [32:0] e;
    clear_log();
    row_ready_i = 1'b1;
    start_job(12'h400, 13'd6);
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    n_checks++; if ({ub_read_o, ub_addr_rd_o, row_valid_o, row_data_o, row_last_o, busy_o, done_o} !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got rd=%b a=%h v=%b d=%h l=%b b=%b dn=%b want all 0", ub_read_o, ub_addr_rd_o, row_valid_o, row_data_o, row_last_o, busy_o, done_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (row_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got v=%b busy=%b want 0 0", row_valid_o, busy_o); end
    rst_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    n_checks++; if (done_cnt != 0 || row_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_aborted: got done=%0d v=%b want 0 0", done_cnt, row_valid_o); end
    clear_log();
    start_job(12'h010, 13'd4);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout: got no done want done"); end
    @(negedge clk_i);
    n_checks++; if (rd_q.size() != 4 || row_q.size() != 4 || done_cnt != 1) begin n_fail++; $display("FAIL rstmid_counts: got reads=%0d rows=%0d done=%0d want 4 4 1", rd_q.size(), row_q.size(), done_cnt); end
    for (int i = 0; i < 4 && i < row_q.size(); i++) begin
      e = {(i == 3), exp_row(12'(12'h010 + i))};
      n_checks++; if (row_q[i] !== e || rd_q[i] !== 12'(12'h010 + i)) begin n_fail++; $display("FAIL rstmid_row_%0d: got addr=%h row=%h want addr=%h row=%h", i, rd_q[i], row_q[i], 12'(12'h010 + i), e); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_wrap();
    test_backpressure();
    test_zero_rows();
    test_start_while_busy();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ub_read_sequencer.md
UB_READ_SEQUENCER -- requirements
Module: ub_read_sequencer

Interface
REQ-001 The block SHALL take its parameters from tpu_package: MUL_SIZE is the lane count, and ACT_WIDTH defines the lane width as ACT_WIDTH+1 bits.
REQ-002 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request pulse; it is accepted only in IDLE.
REQ-005 base_addr_i  input  12  first unified-buffer row address; sampled when start_i is accepted.
REQ-006 num_rows_i  input  13  number of rows to read (0..4096); sampled when start_i is accepted.
REQ-007 ub_read_o  output  1  drives the unified buffer read enable.
REQ-008 ub_addr_rd_o  output  12  drives the unified buffer read address.
REQ-009 ub_data_i  input  [ACT_WIDTH:0] x MUL_SIZE  unified buffer read data; valid exactly 1 cycle after ub_read_o; held by the memory otherwise.
REQ-010 row_valid_o  output  1  an output row is available.
REQ-011 row_ready_i  input  1  the consumer accepts the row; a transfer occurs when row_valid_o and row_ready_i are both 1 at a rising edge.
REQ-012 row_data_o  output  [ACT_WIDTH:0] x MUL_SIZE  output row payload.
REQ-013 row_last_o  output  1  marks the final row of the job; qualified by row_valid_o.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  one-cycle pulse on job completion.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE with start_i=1 and num_rows_i>0: latch the base address and row count, then go to RUN.
REQ-018 IDLE with start_i=1 and num_rows_i=0: go directly to DONE; no read is issued.
REQ-019 start_i outside IDLE SHALL be ignored; the job in progress is unaffected.
REQ-020 RUN SHALL assert ub_read_o=1 with ub_addr_rd_o = base + issued-count (mod 4096) whenever credit is available; issued-count increments on each such cycle.
REQ-021 Credit rule: a read issues only if (entries in the output buffer + reads in flight) < 2, so no returned row is ever dropped.
REQ-022 Address arithmetic SHALL be 12-bit and wrap from 4095 to 0 (e.g. base 4094 with 3 rows reads 4094, 4095, 0).
REQ-023 Each row returned one cycle after its read SHALL be written into a 2-entry FIFO in issue order.
REQ-024 row_valid_o SHALL equal "FIFO not empty", and row_data_o SHALL present the FIFO head.
REQ-025 row_last_o SHALL be 1 only while the head entry is the job's final row.
REQ-026 Throughput: with row_ready_i held at 1, one row SHALL transfer per cycle.
REQ-027 First-row latency: row_valid_o rises 2 cycles after the cycle in which start_i is accepted.
REQ-028 row_valid_o SHALL stay high and row_data_o stable while row_ready_i=0 (no retraction).
REQ-029 Simultaneous FIFO write and pop in the same cycle SHALL keep the occupancy unchanged.
REQ-030 When the last read has been issued, the FSM SHALL move from RUN to DRAIN.
REQ-031 DRAIN SHALL move to DONE in the cycle after the transfer of the last row.
REQ-032 DONE SHALL assert done_o for exactly 1 cycle and then return to IDLE; busy_o=0 in IDLE.
REQ-033 ub_read_o SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-034 While rst_i=0, the state SHALL be IDLE and the FIFO, counters and in-flight flag SHALL be cleared, immediately and independently of clk_i.
REQ-035 Reset values of all outputs SHALL be 0: ub_read_o, ub_addr_rd_o, row_valid_o, row_data_o (all lanes), row_last_o, busy_o, done_o.
REQ-036 A reset asserted mid-job SHALL abort the job with no done_o pulse; the row still in flight SHALL be discarded.

Structure
REQ-037 The FIFO depth constant (2) and the FSM state enum type SHALL be defined in tpu_package.
REQ-038 The 2-entry FIFO SHALL be a separate sub-module named ub_row_fifo; the address counter, credit logic and FSM stay in ub_read_sequencer.

Verification
REQ-039 Streaming: base=0x010, rows=4, ready held 1 -> reads at 0x010..0x013 on 4 consecutive cycles; rows out in order; last flagged on row 4; done_o pulses once.
REQ-040 Wrap-around: base=0xFFE, rows=3 -> addresses 0xFFE, 0xFFF, 0x000.
REQ-041 Backpressure: rows=5, ready=0 for 6 cycles then 1 -> at most 2 reads issue during the stall; row_data_o stable while stalled; all 5 rows delivered without loss or duplication.
REQ-042 Zero rows: start with rows=0 -> no ub_read_o; done_o one cycle after start; busy_o high for 1 cycle.
REQ-043 Start while busy: second start_i mid-job with different base -> ignored; first job completes unchanged.
REQ-044 Reset mid-job: rst_i low during RUN -> all outputs 0 immediately; no done_o; a fresh job after release behaves as in REQ-039.
